// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
//   Shares one combinational WIDTH-bit ALU between two requesters
//   (req0 = execute stage, req1 = auxiliary/test master). Requests are
//   arbitrated round-robin. The granted control word and operands are held
//   stable on the ALU inputs for the op's latency. The result and carry are
//   then captured and returned over a response channel. Only one op is in
//   flight at any time.
//
// Handshake rule (request and response channels alike): a transfer happens
// on a rising clk edge where valid && ready are both high. A producer keeps
// its payload stable while valid is high and ready is low. ready may depend
// combinationally on valid. valid never depends on ready.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   reqN_valid/ready      request handshake, N = 0,1
//   reqN_vlera/a/b        ALU control word (bit3 bnegate, bits2:0 op) and operands
//   alu_vlera/a/b         registered drive into the ALU
//   alu_rezultati/cout    combinational ALU outputs
//   rsp_valid/ready       response handshake
//   rsp_id                index of the requester that issued the op
//   rsp_rezultati/cout    captured ALU result and carry
//   busy                  high whenever the FSM is not in IDLE
//   op_count              number of completed (handshaken) responses, wraps
module alu_req_scheduler #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_vlera,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_vlera,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_vlera,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_rezultati,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_rezultati,
  output logic             rsp_cout,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  // The counter holds the remaining EXEC cycles minus one, i.e. at most MAX_LAT-1.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               last_grant;
  logic               cur_id;
  logic [15:0]        op_count_q;

  logic               grant_id;
  logic [3:0]         grant_vlera;
  logic [WIDTH-1:0]   grant_a;
  logic [WIDTH-1:0]   grant_b;
  logic [CNT_W-1:0]   grant_cnt;
  logic               accept;

  assign op_count = op_count_q;

  // Arbitration. A lone requester wins outright. Under contention, the
  // requester that did not win last time gets the grant.
  always_comb begin
    grant_id    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    grant_vlera = grant_id ? req1_vlera : req0_vlera;
    grant_a     = grant_id ? req1_a     : req0_a;
    grant_b     = grant_id ? req1_b     : req0_b;
    // Multiply is the only op that gets a different settle time.
    grant_cnt   = (grant_vlera[2:0] == 3'b111) ? CNT_W'(MUL_LAT - 1)
                                               : CNT_W'(ALU_LAT - 1);
  end

  // Output decode
  always_comb begin
    req0_ready = !reset && (state == IDLE) && req0_valid && !grant_id;
    req1_ready = !reset && (state == IDLE) && req1_valid &&  grant_id;
    busy       = (state != IDLE);
  end

  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)          state_nx = EXEC;
      EXEC:    if (cnt == '0)       state_nx = RESP;
      RESP:    if (rsp_ready)       state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      cur_id        <= 1'b0;
      alu_vlera     <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= 1'b0;
      rsp_rezultati <= '0;
      rsp_cout      <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_vlera  <= grant_vlera;
            alu_a      <= grant_a;
            alu_b      <= grant_b;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            cnt        <= grant_cnt;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_rezultati <= alu_rezultati;
            rsp_cout      <= alu_cout;
            rsp_id        <= cur_id;
            rsp_valid     <= 1'b1;
          end
        end
        RESP: begin
          // rsp_* and alu_* keep their values until the consumer takes the response.
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            op_count_q <= op_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Testbench for alu_req_scheduler. A behavioural ALU model drives
// alu_rezultati/alu_cout from the scheduler's alu_* outputs. Expected
// values are computed from the request operands and the arbitration rules.
module tb_alu_req_scheduler;

  localparam int W       = 16;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_vlera = '0, req1_vlera = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]   alu_vlera;
  logic [W-1:0] alu_a, alu_b, alu_rezultati;
  logic         alu_cout;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_rezultati;
  logic [15:0]  op_count;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_req_scheduler #(.WIDTH(W), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_vlera(req0_vlera),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_vlera(req1_vlera),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_vlera(alu_vlera), .alu_a(alu_a), .alu_b(alu_b),
    .alu_rezultati(alu_rezultati), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_rezultati(rsp_rezultati), .rsp_cout(rsp_cout),
    .busy(busy), .op_count(op_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model: returns {cout, result} ----------------
  function automatic logic [W:0] alu_fn(input logic [3:0] v, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0]   bb;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    bb = v[3] ? ~b : b;
    s  = '0;
    case (v[2:0])
      3'b000: s = {1'b0, a & bb};
      3'b001: s = {1'b0, a | bb};
      3'b010: s = {1'b0, a ^ bb};
      3'b011: s = {1'b0, ~(a | bb)};
      3'b100: s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, v[3]};
      3'b101: s = {1'b0, a << 1};
      3'b110: s = {1'b0, a >> 1};
      default: begin p = a * b; s = {1'b0, p[W-1:0]}; end
    endcase
    return s;
  endfunction

  always_comb {alu_cout, alu_rezultati} = alu_fn(alu_vlera, alu_a, alu_b);

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one op from requester id with rsp_ready high. lat = edges from the
  // accept edge until rsp_valid is seen (-1 if a bound expired).
  task automatic do_op(input logic id, input logic [3:0] v, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int lat, output logic rid,
                       output logic [W-1:0] res, output logic rc);
    int w;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_vlera = v; req1_a = a; req1_b = b; req0_valid = 1'b0; end
    else    begin req0_valid = 1'b1; req0_vlera = v; req0_a = a; req0_b = b; req1_valid = 1'b0; end
    #1;
    w = 0;
    while (!(id ? req1_ready : req0_ready) && w < 20) begin @(negedge clk); #1; w++; end
    lat = -1; rid = 1'bx; res = 'x; rc = 1'bx;
    if (w >= 20) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
    if (rsp_valid) begin lat = w; rid = rsp_id; res = rsp_rezultati; rc = rsp_cout; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_vlera = 4'b0100; req0_a = 16'h1234; req0_b = 16'h0001;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    n_cmp++; if ({rsp_valid, rsp_id, rsp_cout, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got v/id/c/busy=%b want 0000", {rsp_valid, rsp_id, rsp_cout, busy}); end
    n_cmp++; if ({alu_vlera, alu_a, alu_b, rsp_rezultati, op_count} !== '0) begin n_fail++; $display("FAIL reset_regs: vlera=%h a=%h b=%h res=%h cnt=%h want all 0", alu_vlera, alu_a, alu_b, rsp_rezultati, op_count); end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_add();
    int lat; logic rid, rc; logic [W-1:0] res;
    do_reset();
    do_op(1'b0, 4'b0100, 16'h0003, 16'h0004, lat, rid, res, rc);
    n_cmp++; if (lat !== ALU_LAT) begin n_fail++; $display("FAIL add_latency: got %0d want %0d", lat, ALU_LAT); end
    n_cmp++; if ({rid, rc, res} !== {1'b0, 1'b0, 16'h0007}) begin n_fail++; $display("FAIL add_rsp: got id=%b c=%b r=%h want id=0 c=0 r=0007", rid, rc, res); end
    @(negedge clk);
    n_cmp++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_count: got cnt=%0d v=%b want 1 0", op_count, rsp_valid); end
  endtask

  task automatic test_sub();
    int lat; logic rid, rc; logic [W-1:0] res;
    do_reset();
    do_op(1'b1, 4'b1100, 16'h0005, 16'h0003, lat, rid, res, rc);
    n_cmp++; if ({rid, rc, res} !== {1'b1, 1'b1, 16'h0002}) begin n_fail++; $display("FAIL sub1_rsp: got id=%b c=%b r=%h want id=1 c=1 r=0002", rid, rc, res); end
    do_op(1'b1, 4'b1100, 16'h0000, 16'h0001, lat, rid, res, rc);
    n_cmp++; if ({rid, rc, res} !== {1'b1, 1'b0, 16'hFFFF}) begin n_fail++; $display("FAIL sub2_rsp: got id=%b c=%b r=%h want id=1 c=0 r=FFFF", rid, rc, res); end
    @(negedge clk);
    n_cmp++; if (op_count !== 16'd2) begin n_fail++; $display("FAIL sub_count: got %0d want 2", op_count); end
  endtask

  task automatic test_mul();
    int busy_cycles;
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_vlera = 4'b0111; req0_a = 16'h0012; req0_b = 16'h0034;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_accept: got r0=%b r1=%b busy=%b want 1 0 0", req0_ready, req1_ready, busy); end
    busy_cycles = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req0_valid = 1'b0;
      #1;
      if (busy) busy_cycles++;
      n_cmp++; if (rsp_valid !== (k == MUL_LAT + 1)) begin n_fail++; $display("FAIL mul_rsp_valid: cycle %0d got %b want %b", k, rsp_valid, k == MUL_LAT + 1); end
      n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL mul_ready_drop: cycle %0d got %b want 0", k, req0_ready); end
      if (k == MUL_LAT + 1) begin
        n_cmp++; if (rsp_rezultati !== 16'h03A8 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL mul_result: got r=%h id=%b want 03A8 0", rsp_rezultati, rsp_id); end
      end
    end
    n_cmp++; if (busy_cycles !== MUL_LAT + 1) begin n_fail++; $display("FAIL mul_busy: got %0d cycles want %0d", busy_cycles, MUL_LAT + 1); end
  endtask

  task automatic test_contention();
    int w;
    do_reset();
    @(negedge clk);
    rsp_ready  = 1'b1;
    req0_valid = 1'b1; req0_vlera = 4'b0100; req0_a = 16'h0010; req0_b = 16'h0001;
    req1_valid = 1'b1; req1_vlera = 4'b0100; req1_a = 16'h0020; req1_b = 16'h0002;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== k[0]) begin n_fail++; $display("FAIL rr_order: rsp %0d got v=%b id=%b want v=1 id=%0d", k, rsp_valid, rsp_id, k % 2); end
      n_cmp++; if (rsp_rezultati !== (k[0] ? 16'h0022 : 16'h0011)) begin n_fail++; $display("FAIL rr_result: rsp %0d got %h want %h", k, rsp_rezultati, k[0] ? 16'h0022 : 16'h0011); end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b0; req0_valid = 1'b1; req0_vlera = 4'b0000; req0_a = 16'hF0F0; req0_b = 16'hFF00;
    w = 0;
    while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_wait: rsp_valid got %b want 1", rsp_valid); end
    req1_valid = 1'b1; req1_vlera = 4'b0100; req1_a = 16'h0001; req1_b = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      n_cmp++; if ({rsp_valid, rsp_id, rsp_cout, rsp_rezultati} !== {1'b1, 1'b0, 1'b0, 16'hF000}) begin n_fail++; $display("FAIL bp_rsp_hold: cycle %0d got v=%b id=%b c=%b r=%h want 1 0 0 F000", k, rsp_valid, rsp_id, rsp_cout, rsp_rezultati); end
      n_cmp++; if ({alu_vlera, alu_a, alu_b} !== {4'b0000, 16'hF0F0, 16'hFF00}) begin n_fail++; $display("FAIL bp_alu_hold: cycle %0d got %h %h %h want 0 F0F0 FF00", k, alu_vlera, alu_a, alu_b); end
      n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || op_count !== 16'd0) begin n_fail++; $display("FAIL bp_stall: cycle %0d got r0=%b r1=%b cnt=%0d want 0 0 0", k, req0_ready, req1_ready, op_count); end
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got cnt=%0d v=%b want 1 0", op_count, rsp_valid); end
  endtask

  task automatic test_reset_mid_exec();
    int lat; logic rid, rc; logic [W-1:0] res;
    do_reset();
    do_op(1'b0, 4'b0100, 16'h0001, 16'h0001, lat, rid, res, rc);
    @(negedge clk);
    n_cmp++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL rst_pre_count: got %0d want 1", op_count); end
    req0_valid = 1'b1; req0_vlera = 4'b0111; req0_a = 16'h0002; req0_b = 16'h0003;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mul_accept: got %b want 1", req0_ready); end
    @(negedge clk);
    reset = 1'b1; req1_valid = 1'b1; req1_vlera = 4'b0100;
    #1;
    n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_low: got %b%b want 00", req0_ready, req1_ready); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, busy} !== 2'b00 || op_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_state: got v=%b busy=%b cnt=%0d want 0 0 0", rsp_valid, busy, op_count); end
    n_cmp++; if ({alu_vlera, alu_a, rsp_rezultati} !== '0) begin n_fail++; $display("FAIL rst_mid_regs: got %h %h %h want 0", alu_vlera, alu_a, rsp_rezultati); end
    reset = 1'b0;
    #1;
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_first_grant: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int lat; logic rid, rc; logic [W-1:0] res;
    do_reset();
    @(negedge clk);
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    #1;
    n_cmp++; if (op_count !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_preload: got %h want FFFE", op_count); end
    do_op(1'b1, 4'b0001, 16'h00F0, 16'h000F, lat, rid, res, rc);
    @(negedge clk);
    n_cmp++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h want FFFF", op_count); end
    do_op(1'b0, 4'b0010, 16'h00FF, 16'h0F0F, lat, rid, res, rc);
    @(negedge clk);
    n_cmp++; if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", op_count); end
  endtask

  // Random traffic against a transaction-level model: one op in flight,
  // round-robin grant, result due LAT edges after the accept edge.
  task automatic test_random();
    logic [W+1:0] exp_q[$];   // {id, cout, result}
    logic         m_busy, m_last, g, exp_rv;
    int           m_age, m_lat, m_cnt;
    logic [3:0]   m_v;
    logic [W-1:0] m_a, m_b;
    do_reset();
    m_busy = 1'b0; m_last = 1'b1; m_age = 0; m_lat = 0; m_cnt = 0;
    m_v = '0; m_a = '0; m_b = '0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (m_busy) m_age++;
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_vlera = 4'($urandom_range(0, 15)); req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_vlera = 4'($urandom_range(0, 15)); req1_a = 16'($urandom); req1_b = 16'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      exp_rv = m_busy && (m_age >= m_lat + 1);
      g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      n_cmp++; if (busy !== m_busy || rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_status: i=%0d got busy=%b v=%b want %b %b", i, busy, rsp_valid, m_busy, exp_rv); end
      n_cmp++; if (req0_ready !== (!m_busy && req0_valid && !g) || req1_ready !== (!m_busy && req1_valid && g)) begin n_fail++; $display("FAIL rnd_grant: i=%0d got r0=%b r1=%b want %b %b", i, req0_ready, req1_ready, !m_busy && req0_valid && !g, !m_busy && req1_valid && g); end
      n_cmp++; if (op_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_count: i=%0d got %0d want %0d", i, op_count, 16'(m_cnt)); end
      if (m_busy) begin
        n_cmp++; if ({alu_vlera, alu_a, alu_b} !== {m_v, m_a, m_b}) begin n_fail++; $display("FAIL rnd_alu_hold: i=%0d got %h %h %h want %h %h %h", i, alu_vlera, alu_a, alu_b, m_v, m_a, m_b); end
      end
      if (exp_rv && exp_q.size() > 0) begin
        n_cmp++; if ({rsp_id, rsp_cout, rsp_rezultati} !== exp_q[0]) begin n_fail++; $display("FAIL rnd_rsp: i=%0d got id=%b c=%b r=%h want %h", i, rsp_id, rsp_cout, rsp_rezultati, exp_q[0]); end
      end
      if (exp_rv && rsp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_cnt  = (m_cnt + 1) % 65536;
        m_busy = 1'b0;
      end else if (!m_busy && (req0_valid || req1_valid)) begin
        m_v = g ? req1_vlera : req0_vlera;
        m_a = g ? req1_a     : req0_a;
        m_b = g ? req1_b     : req0_b;
        m_lat  = (m_v[2:0] == 3'b111) ? MUL_LAT : ALU_LAT;
        m_busy = 1'b1; m_age = 0; m_last = g;
        exp_q.push_back({g, alu_fn(m_v, m_a, m_b)});
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Sequencer/arbiter sharing the single 16-bit ALU (4-bit control word: bit3 = bnegate, bits2:0 = op) between two requesters (req0 = execute stage, req1 = auxiliary/test master).
- Arbitrates round-robin, holds operands and control stable at the ALU for the op's latency, captures result/carry, returns them over a valid/ready response channel.
- Sits between requesters and the ALU instance; ALU stays combinational, multiply (op 3'b111) is allotted extra settle cycles.

Parameters:
- WIDTH, 16, operand/result width (must match ALU)
- ALU_LAT, 1, EXEC cycles for ops other than 3'b111 (>=1)
- MUL_LAT, 2, EXEC cycles for op 3'b111 (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_vlera / req1_vlera  in  4  ALU control word
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_vlera  out  4  to ALU control
- alu_a, alu_b  out  WIDTH  to ALU operands
- alu_rezultati  in  WIDTH  ALU result
- alu_cout  in  1  ALU carry-out
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index of response
- rsp_rezultati  out  WIDTH  captured result
- rsp_cout  out  1  captured carry
- busy  out  1  state != IDLE
- op_count  out  16  completed ops (handshaken responses)

Behaviour:
- Clock/reset: one clock clk; reset synchronous, active-high. Reset values: state IDLE, alu_vlera/alu_a/alu_b = 0, rsp_valid/rsp_id/rsp_rezultati/rsp_cout = 0, op_count = 0, last_grant = 1 (req0 wins first contention). req*_ready = 0 while reset high.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE: grant = only valid requester; both valid -> requester != last_grant. req_ready = (state==IDLE) && granted (combinational, one-hot); none valid -> no ready. On valid&ready edge: latch vlera/a/b into alu_* regs, latch id, load cnt = (vlera[2:0]==3'b111 ? MUL_LAT : ALU_LAT) - 1, last_grant <= id, go EXEC.
- EXEC: alu_* held constant. cnt != 0 -> decrement. cnt == 0 -> capture alu_rezultati/alu_cout/id into rsp regs, rsp_valid <= 1, go RESP.
- RESP: all rsp_* and alu_* held stable while rsp_ready low (no new accepts). rsp_valid&rsp_ready edge -> rsp_valid <= 0, op_count <= op_count+1 (wraps 0xFFFF -> 0x0000), go IDLE.
- Latency: accept at edge T -> rsp_valid high after edge T+LAT (LAT = ALU_LAT or MUL_LAT). Min issue interval LAT+2 cycles; no overlap, one op in flight.
- Control word passed unmodified; scheduler does not interpret op except 3'b111 latency select (sub = 4'b1100 etc. per ALU encoding). Shifts use a only; b still forwarded.
- Requester changing inputs while not granted has no effect; operands sampled only on handshake edge.
- Reset mid-EXEC/RESP: op discarded, no response, op_count unchanged-from-reset (0), all values as reset list next cycle.
- busy = (state != IDLE).

Test Plan:
- req0 ADD vlera=4'b0100, a=0x0003, b=0x0004, rsp_ready=1 -> req0_ready high 1 cycle; rsp_valid 1 cycle after accept, rsp_id=0, rsp_rezultati=0x0007, rsp_cout=0, op_count=1.
- req1 SUB vlera=4'b1100, a=0x0005, b=0x0003 -> rsp_id=1, rsp_rezultati=0x0002; then SUB a=0x0000 b=0x0001 -> 0xFFFF.
- Multiply vlera=4'b0111, a=0x0012, b=0x0034 (MUL_LAT=2) -> busy 3 cycles incl. RESP, rsp_valid 2 cycles after accept, rsp_rezultati=0x03A8.
- Both valid from reset, held: grants req0, req1, req0, req1 alternating; rsp_id sequence 0,1,0,1.
- rsp_ready low 5 cycles after rsp_valid -> rsp_* and alu_* unchanged, req*_ready stay 0, op_count unchanged until handshake.
- Reset pulsed during EXEC of multiply -> next cycle rsp_valid=0, busy=0, op_count=0; subsequent contention granted to req0. Separately: force 65536 completions -> op_count wraps to 0x0000.
